// File: rtl/mdu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_issue_ctrl
//
// E-stage issue and interlock controller for the multiply/divide unit. Decodes
// mult/multu/div/divu/mfhi/mflo/mthi/mtlo requests into the MDU Start,
// MDU_Sel, HI_En, LO_En and WrHL controls. It stalls the pipeline across the
// one-cycle gap between Start and MDU Busy rising, and across the Busy window
// itself. A watchdog raises a sticky Err when Busy stays high too long.
//
// Parameters
//   TIMEOUT       cycles in WAIT with Busy high before Err is set. Must be at
//                 least 11, which is longer than the 10-cycle divide.
//
// Ports
//   Clk           rising-edge clock
//   Rst_n         asynchronous active-low reset
//   Op            request code: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI,
//                 6 MFLO, 7 MTHI, 8 MTLO; all other codes mean no request
//   Op_Valid      Op qualifies this cycle
//   Flush         kill the E-stage instruction this cycle
//   Rs_Data       operand 1; also the MTHI/MTLO write data
//   Rt_Data       operand 2
//   MDU_Busy      Busy from the MDU
//   MDU_HI/LO     HI/LO registers of the MDU
//   Start         MDU start pulse
//   MDU_Sel       MDU operation select (0 MULT, 1 MULTU, 2 DIV, 3 DIVU)
//   MDU_D1/D2     MDU operands (pass-through)
//   HI_En/LO_En   MDU direct HI/LO write enables
//   WrHL          MDU direct-write data
//   Stall         freeze the E stage and all earlier stages
//   Result        MFHI/MFLO read value
//   Result_Valid  Result is meaningful this cycle
//   Last_Sel      MDU_Sel of the most recently issued operation
//   Err           sticky MDU timeout flag
// -----------------------------------------------------------------------------
module mdu_issue_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [3:0]  Op,
  input  logic        Op_Valid,
  input  logic        Flush,
  input  logic [31:0] Rs_Data,
  input  logic [31:0] Rt_Data,
  input  logic        MDU_Busy,
  input  logic [31:0] MDU_HI,
  input  logic [31:0] MDU_LO,
  output logic        Start,
  output logic [1:0]  MDU_Sel,
  output logic [31:0] MDU_D1,
  output logic [31:0] MDU_D2,
  output logic        HI_En,
  output logic        LO_En,
  output logic [31:0] WrHL,
  output logic        Stall,
  output logic [31:0] Result,
  output logic        Result_Valid,
  output logic [1:0]  Last_Sel,
  output logic        Err
);

  // The counter must hold TIMEOUT and is never narrower than 5 bits.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 5) ? 5 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       last_sel_r;
  logic             err_r;

  logic        arith_s;
  logic        mdu_op_s;
  logic [1:0]  sel_s;
  logic        req_s;
  logic        stall_s;
  logic        go_s;
  logic        start_s;
  logic        hi_en_s;
  logic        lo_en_s;
  logic [31:0] result_s;
  logic        result_valid_s;

  // Request decode, interlock and the combinational MDU controls.
  always_comb begin
    arith_s  = 1'b0;
    mdu_op_s = 1'b0;
    sel_s    = 2'd0;
    result_s = 32'd0;
    case (Op)
      4'd1: begin arith_s = 1'b1; mdu_op_s = 1'b1; sel_s = 2'd0; end
      4'd2: begin arith_s = 1'b1; mdu_op_s = 1'b1; sel_s = 2'd1; end
      4'd3: begin arith_s = 1'b1; mdu_op_s = 1'b1; sel_s = 2'd2; end
      4'd4: begin arith_s = 1'b1; mdu_op_s = 1'b1; sel_s = 2'd3; end
      4'd5: begin mdu_op_s = 1'b1; result_s = MDU_HI; end
      4'd6: begin mdu_op_s = 1'b1; result_s = MDU_LO; end
      4'd7: begin mdu_op_s = 1'b1; end
      4'd8: begin mdu_op_s = 1'b1; end
      default: begin
        arith_s  = 1'b0;
        mdu_op_s = 1'b0;
      end
    endcase

    // An unqualified Op must not leak onto the select or result buses.
    if (!Op_Valid) begin
      sel_s    = 2'd0;
      result_s = 32'd0;
    end else begin
      sel_s    = sel_s;
      result_s = result_s;
    end

    req_s = Op_Valid & mdu_op_s;
    // ISSUED covers the cycle between Start and Busy being seen high.
    // Flush deliberately does not enter here, so a flushed slot keeps stalling.
    stall_s        = req_s & ((state_r == ST_ISSUED) | MDU_Busy);
    go_s           = req_s & ~stall_s & ~Flush;
    start_s        = go_s & arith_s;
    hi_en_s        = go_s & (Op == 4'd7);
    lo_en_s        = go_s & (Op == 4'd8);
    result_valid_s = go_s & ((Op == 4'd5) | (Op == 4'd6));
  end

  // Issue-tracking FSM with busy watchdog, last-select and sticky error.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      last_sel_r <= 2'd0;
      err_r      <= 1'b0;
    end else begin
      if (start_s) begin
        last_sel_r <= sel_s;
      end
      case (state_r)
        ST_IDLE: begin
          cnt_r   <= CNT_ZERO;
          state_r <= start_s ? ST_ISSUED : ST_IDLE;
        end
        ST_ISSUED: begin
          // The MDU raises Busy in this cycle; start watching from WAIT.
          cnt_r   <= CNT_ZERO;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (MDU_Busy) begin
            if (cnt_r == CNT_LAST) begin
              // Give up on the MDU but keep running so the core is not wedged.
              err_r   <= 1'b1;
              cnt_r   <= CNT_ZERO;
              state_r <= ST_IDLE;
            end else begin
              cnt_r   <= cnt_r + CNT_ONE;
              state_r <= ST_WAIT;
            end
          end else begin
            // Busy has fallen: act as IDLE so a back-to-back op issues now.
            cnt_r   <= CNT_ZERO;
            state_r <= start_s ? ST_ISSUED : ST_IDLE;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign Start        = start_s;
  assign MDU_Sel      = sel_s;
  assign MDU_D1       = Rs_Data;
  assign MDU_D2       = Rt_Data;
  assign HI_En        = hi_en_s;
  assign LO_En        = lo_en_s;
  assign WrHL         = Rs_Data;
  assign Stall        = stall_s;
  assign Result       = result_s;
  assign Result_Valid = result_valid_s;
  assign Last_Sel     = last_sel_r;
  assign Err          = err_r;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_issue_ctrl
//
// Self-checking bench for mdu_issue_ctrl. A behavioural MDU (Busy window,
// 64-bit multiply, divide, direct HI/LO writes) surrounds the DUT. A reference
// model derived from the request/stall/grant rules predicts every output each
// cycle. Directed steps follow the test plan, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_mdu_issue_ctrl;
  localparam int TIMEOUT = 16;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [3:0]  Op;
  logic        Op_Valid;
  logic        Flush;
  logic [31:0] Rs_Data;
  logic [31:0] Rt_Data;
  logic        MDU_Busy;
  logic [31:0] MDU_HI;
  logic [31:0] MDU_LO;
  logic        Start;
  logic [1:0]  MDU_Sel;
  logic [31:0] MDU_D1;
  logic [31:0] MDU_D2;
  logic        HI_En;
  logic        LO_En;
  logic [31:0] WrHL;
  logic        Stall;
  logic [31:0] Result;
  logic        Result_Valid;
  logic [1:0]  Last_Sel;
  logic        Err;

  mdu_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Op(Op), .Op_Valid(Op_Valid), .Flush(Flush),
    .Rs_Data(Rs_Data), .Rt_Data(Rt_Data), .MDU_Busy(MDU_Busy),
    .MDU_HI(MDU_HI), .MDU_LO(MDU_LO), .Start(Start), .MDU_Sel(MDU_Sel),
    .MDU_D1(MDU_D1), .MDU_D2(MDU_D2), .HI_En(HI_En), .LO_En(LO_En),
    .WrHL(WrHL), .Stall(Stall), .Result(Result), .Result_Valid(Result_Valid),
    .Last_Sel(Last_Sel), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural MDU
  int          env_busy_cnt;
  bit          env_hang;
  bit          env_stuck;
  logic [31:0] env_hi, env_lo, pend_hi, pend_lo;

  // Reference model
  bit          m_prev_start;
  bit          m_in_wait;
  bit          m_err;
  int          m_busy_run;
  logic [1:0]  m_last_sel;

  // Values captured at the negative edge of the last cycle
  logic        obs_start, obs_stall, obs_rv, obs_lo_en, obs_hi_en, obs_err, obs_busy;
  logic [1:0]  obs_sel, obs_last_sel;
  logic [31:0] obs_result, obs_wrhl, obs_d1, obs_d2;
  bit          e_start;
  logic [1:0]  e_sel;

  int n;
  int pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input bit v, input bit fl,
                       input logic [31:0] rs, input logic [31:0] rt);
    Op = op; Op_Valid = v; Flush = fl; Rs_Data = rs; Rt_Data = rt;
  endtask

  task automatic clear_models();
    env_busy_cnt = 0; env_hang = 1'b0; env_stuck = 1'b0;
    env_hi = 32'd0; env_lo = 32'd0; pend_hi = 32'd0; pend_lo = 32'd0;
    MDU_Busy = 1'b0; MDU_HI = 32'd0; MDU_LO = 32'd0;
    m_prev_start = 1'b0; m_in_wait = 1'b0; m_err = 1'b0;
    m_busy_run = 0; m_last_sel = 2'd0;
  endtask

  task automatic mdu_compute(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    int          ia, ib;
    case (sel)
      2'd0: begin
        sa = longint'(signed'(a)); sb = longint'(signed'(b)); sp = sa * sb;
        up = 64'(sp); pend_hi = up[63:32]; pend_lo = up[31:0];
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b}; pend_hi = up[63:32]; pend_lo = up[31:0];
      end
      2'd2: begin
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
          pend_hi = 32'd0; pend_lo = 32'd0;
        end else begin
          ia = int'(a); ib = int'(b);
          pend_lo = 32'(ia / ib); pend_hi = 32'(ia % ib);
        end
      end
      default: begin
        if (b == 32'd0) begin
          pend_hi = 32'd0; pend_lo = 32'd0;
        end else begin
          pend_lo = a / b; pend_hi = a % b;
        end
      end
    endcase
  endtask

  // One clock cycle: check outputs against the model, then advance the world.
  task automatic tick();
    bit          arith, mdu, req, stall, go;
    logic [31:0] res;
    @(negedge Clk);
    arith = (Op >= 4'd1) && (Op <= 4'd4);
    mdu   = (Op >= 4'd1) && (Op <= 4'd8);
    req   = Op_Valid && mdu;
    stall = req && (m_prev_start || MDU_Busy);
    go    = req && !stall && !Flush;
    e_start = go && arith;
    e_sel   = arith ? 2'(Op - 4'd1) : 2'd0;
    res = (Op == 4'd5) ? env_hi : ((Op == 4'd6) ? env_lo : 32'd0);
    chk("stall", 32'(Stall), 32'(stall));
    chk("start", 32'(Start), 32'(e_start));
    chk("mdu_sel", 32'(MDU_Sel), 32'(e_sel));
    chk("hi_en", 32'(HI_En), 32'(go && (Op == 4'd7)));
    chk("lo_en", 32'(LO_En), 32'(go && (Op == 4'd8)));
    chk("result_valid", 32'(Result_Valid), 32'(go && (Op == 4'd5 || Op == 4'd6)));
    chk("result", Result, res);
    chk("wrhl", WrHL, Rs_Data);
    chk("d1", MDU_D1, Rs_Data);
    chk("d2", MDU_D2, Rt_Data);
    chk("last_sel", 32'(Last_Sel), 32'(m_last_sel));
    chk("err", 32'(Err), 32'(m_err));
    obs_start = Start; obs_stall = Stall; obs_rv = Result_Valid; obs_lo_en = LO_En;
    obs_hi_en = HI_En; obs_err = Err; obs_sel = MDU_Sel; obs_last_sel = Last_Sel;
    obs_result = Result; obs_wrhl = WrHL; obs_d1 = MDU_D1; obs_d2 = MDU_D2;
    obs_busy = MDU_Busy;
    @(posedge Clk);
    #1;
    // MDU reacts to what the DUT actually drove
    if (env_busy_cnt > 0) begin
      env_busy_cnt--;
      if (env_busy_cnt == 0) begin env_hi = pend_hi; env_lo = pend_lo; end
    end
    if (obs_hi_en) env_hi = obs_wrhl;
    if (obs_lo_en) env_lo = obs_wrhl;
    if (obs_start) begin
      mdu_compute(obs_sel, obs_d1, obs_d2);
      env_busy_cnt = (obs_sel >= 2'd2) ? 10 : 5;
      if (env_hang) env_stuck = 1'b1;
    end
    MDU_Busy = env_stuck || (env_busy_cnt > 0);
    MDU_HI = env_hi; MDU_LO = env_lo;
    // Model: a watched op times out after TIMEOUT consecutive busy cycles
    if (e_start) m_last_sel = e_sel;
    if (m_in_wait) begin
      if (obs_busy) begin
        m_busy_run++;
        if (m_busy_run == TIMEOUT) begin
          m_err = 1'b1; m_in_wait = 1'b0; m_busy_run = 0;
        end
      end else begin
        m_in_wait = 1'b0; m_busy_run = 0;
      end
    end
    if (m_prev_start) begin m_in_wait = 1'b1; m_busy_run = 0; end
    m_prev_start = e_start;
  endtask

  // Stall-counting grant loop; leaves n = stalled cycles (40 if never granted).
  task automatic until_grant();
    n = 0; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_lo_en) pulses++;
      if (!obs_stall) break;
      n++;
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    clear_models();
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Reset state, idle outputs
    drive(4'd0, 1'b0, 1'b0, 32'hA5A5_0001, 32'h5A5A_0002);
    tick();
    chk("rst_last_sel", 32'(obs_last_sel), 32'd0);
    chk("rst_err", 32'(obs_err), 32'd0);

    // MULT -1 * 2 then dependent MFHI
    drive(4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
    tick();
    chk("mult_start", 32'(obs_start), 32'd1);
    chk("mult_sel", 32'(obs_sel), 32'd0);
    drive(4'd5, 1'b1, 1'b0, 32'd0, 32'd0);
    until_grant();
    chk("mfhi_stalls", n, 5);
    chk("mfhi_rv", 32'(obs_rv), 32'd1);
    chk("mfhi_val", obs_result, 32'hFFFF_FFFF);
    chk("mult_last_sel", 32'(obs_last_sel), 32'd0);

    // DIVU 7 / 2
    drive(4'd4, 1'b1, 1'b0, 32'd7, 32'd2);
    tick();
    chk("divu_start", 32'(obs_start), 32'd1);
    drive(4'd6, 1'b1, 1'b0, 32'd0, 32'd0);
    until_grant();
    chk("mflo_stalls", n, 10);
    chk("divu_quot", obs_result, 32'd3);
    drive(4'd5, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    chk("divu_rem_nostall", 32'(obs_stall), 32'd0);
    chk("divu_rem", obs_result, 32'd1);
    chk("divu_last_sel", 32'(obs_last_sel), 32'd3);

    // MULT followed by MTLO
    drive(4'd1, 1'b1, 1'b0, 32'd9, 32'd9);
    tick();
    drive(4'd8, 1'b1, 1'b0, 32'h1234, 32'd0);
    until_grant();
    chk("mtlo_stalls", n, 5);
    drive(4'd6, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    chk("mtlo_pulses", pulses + int'(obs_lo_en), 1);
    chk("mtlo_readback", obs_result, 32'h1234);

    // Flushed DIV never issues
    drive(4'd3, 1'b1, 1'b1, 32'd100, 32'd3);
    tick();
    chk("flush_start", 32'(obs_start), 32'd0);
    chk("flush_stall", 32'(obs_stall), 32'd0);
    drive(4'd5, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    chk("flush_idle", 32'(obs_stall), 32'd0);

    // Flush during WAIT
    drive(4'd1, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
    tick();
    drive(4'd5, 1'b1, 1'b1, 32'd0, 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_stall) pulses++;
    end
    chk("flush_wait_stall", pulses, 3);
    drive(4'd5, 1'b1, 1'b0, 32'd0, 32'd0);
    until_grant();
    chk("flush_wait_total", n + 3, 5);
    chk("flush_wait_hi", obs_result, 32'hFFFF_FFFE);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      drive(v ? 4'($urandom_range(0, 15)) : 4'd0, v, ($urandom_range(0, 9) == 0),
            $urandom, $urandom);
      tick();
    end
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (12) tick();

    // MDU that never completes
    env_hang = 1'b1;
    drive(4'd2, 1'b1, 1'b0, 32'd3, 32'd3);
    tick();
    chk("hang_start", 32'(obs_start), 32'd1);
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= TIMEOUT + 1; i++) tick();
    chk("err_not_early", 32'(obs_err), 32'd0);
    tick();
    chk("err_on_time", 32'(obs_err), 32'd1);
    drive(4'd6, 1'b1, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    chk("err_sticky", 32'(obs_err), 32'd1);
    env_hang = 1'b0; env_stuck = 1'b0; env_busy_cnt = 0; MDU_Busy = 1'b0;
    drive(4'd3, 1'b1, 1'b0, 32'd50, 32'd7);
    tick();
    chk("after_err_start", 32'(obs_start), 32'd1);
    tick();
    chk("after_err_still", 32'(obs_err), 32'd1);

    // Asynchronous reset mid-operation
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    assert (Err === 1'b0 && Last_Sel === 2'd0) else begin
      errors++;
      $error("FAIL async_rst: observed err=%0b last_sel=%0d expected 0/0", Err, Last_Sel);
    end
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    clear_models();
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    drive(4'd5, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    chk("post_rst_err", 32'(obs_err), 32'd0);
    chk("post_rst_stall", 32'(obs_stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
